fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Bundles every handshake/bus signal of the fetch unit: the PC input channel,
// the redirect (flush), the instruction-memory request/response channel and
// the decode-facing instruction channel.
//
// Modports
//   master : the fetch unit itself (consumes pc, drives imem requests and the
//            ir_* entry for decode).
//   slave  : the surrounding environment (PC register, imem, decode).
//
// Signals
//   pc[31:0], pc_valid, pc_ready        PC -> fetch handshake
//   flush                               redirect, drop everything in flight
//   imem_req, imem_addr[31:0], imem_gnt request channel to instruction memory
//   imem_rvalid, imem_rdata[31:0]       in-order response channel
//   ir_valid, ir_ready                  fetch -> decode handshake
//   ir_inst[31:0], ir_pc[31:0]          head entry payload
//   ir_misalign                         head entry is a misaligned-fetch marker
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_inst;
    logic [31:0] ir_pc;
    logic        ir_misalign;

    modport master (
        input  pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, ir_ready,
        output pc_ready, imem_req, imem_addr, ir_valid, ir_inst, ir_pc, ir_misalign
    );

    modport slave (
        output pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, ir_ready,
        input  pc_ready, imem_req, imem_addr, ir_valid, ir_inst, ir_pc, ir_misalign
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Single-outstanding instruction fetcher. Accepts a PC, issues one request to
// instruction memory, and queues the returned word together with its PC in a
// 2-entry output FIFO whose head is presented to decode with no bubble.
// A flush drops the FIFO contents and any in-flight fetch; a response that is
// still owed by memory after a flush is swallowed in the DRAIN state.
//
// Ports
//   clk    : clock, all state on posedge
//   rst    : synchronous, active-high reset
//   io_bus : fetch_unit_if.master (pc/flush/imem/ir channels)
//
// Build option
//   FETCH_MISALIGN_CHK_EN : when defined, a PC with pc[1:0]!=0 issues no memory
//   request; instead a marker entry {pc, NOP, misalign=1} is queued at the
//   next edge. When undefined, the low PC bits are ignored for addressing and
//   ir_misalign is constant 0.
// ----------------------------------------------------------------------------
module fetch_unit (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    io_bus
);

    localparam logic [31:0] RESET_ADDR = 32'h0000_8000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } entry_t;

    // ---------------- state ----------------
    state_t      r_state;
    logic [31:0] r_addr;
    entry_t      r_fifo [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_cnt;

    // ---------------- combinational ----------------
    state_t      w_state_nxt;
    logic        w_ir_valid;
    logic        w_pop;
    logic [1:0]  w_cnt_after_pop;
    logic        w_pc_ready;
    logic        w_pc_hs;
    logic        w_misalign;
    logic        w_capture;
    logic        w_push;
    entry_t      w_push_entry;
    entry_t      w_head;

    assign w_head          = r_fifo[r_rd_ptr];
    assign w_ir_valid      = (r_cnt != 2'd0);
    assign w_pop           = w_ir_valid && io_bus.ir_ready;
    assign w_cnt_after_pop = r_cnt - {1'b0, w_pop};

    // Accept a new PC only when idle and a slot is guaranteed for its result.
    // Counting this cycle's pop lets a full FIFO refill without a bubble, and
    // since only one fetch is ever in flight, a push can never meet a full
    // FIFO. pc_ready is held low during the reset cycle.
    assign w_pc_ready = (r_state == IDLE) && !rst && !io_bus.flush &&
                        (w_cnt_after_pop < 2'd2);
    assign w_pc_hs    = w_pc_ready && io_bus.pc_valid;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_misalign = (io_bus.pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state / actions ----------------
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_push       = 1'b0;
        w_push_entry = '{pc: r_addr, inst: io_bus.imem_rdata, misalign: 1'b0};

        unique case (r_state)
            IDLE: begin
                // w_pc_hs already excludes flush, so flush simply stays here.
                if (w_pc_hs) begin
                    if (w_misalign) begin
                        // No memory access: queue a NOP marker right away.
                        w_push       = 1'b1;
                        w_push_entry = '{pc: io_bus.pc, inst: NOP_INST, misalign: 1'b1};
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (io_bus.flush) begin
                    // An ungranted request is simply withdrawn. If memory grants
                    // in the very flush cycle a response is still owed, so it
                    // must be swallowed rather than left to arrive in IDLE.
                    w_state_nxt = io_bus.imem_gnt ? DRAIN : IDLE;
                end else if (io_bus.imem_gnt) begin
                    w_state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (io_bus.flush) begin
                    w_state_nxt = io_bus.imem_rvalid ? IDLE : DRAIN;
                end else if (io_bus.imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                // The owed response is discarded; further flushes just wait.
                if (io_bus.imem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- address register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= RESET_ADDR;
        end else if (w_capture) begin
            r_addr <= io_bus.pc;
        end
    end

    // ---------------- output FIFO ----------------
    // Flush wins over push and pop in the same cycle, including a pop that
    // decode believes it completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (io_bus.flush) begin
            r_cnt    <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_push_entry;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // ---------------- outputs ----------------
    assign io_bus.pc_ready  = w_pc_ready;
    assign io_bus.imem_req  = (r_state == REQ);
    // Memory is word addressed; the unmodified PC travels with the entry.
    assign io_bus.imem_addr = {r_addr[31:2], 2'b00};
    assign io_bus.ir_valid  = w_ir_valid;
    assign io_bus.ir_inst   = w_head.inst;
    assign io_bus.ir_pc     = w_head.pc;
    // Without the misalign check nothing ever stores a 1 here, so this
    // output is constant 0 in that build.
    assign io_bus.ir_misalign = w_head.misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Inputs are applied on the falling edge
// and outputs sampled 1 ns later. A memory responder (auto mode) grants with a
// programmable stall and returns a word the cycle after the grant; hand-driven
// mode is used for flush/reset corner cases. A scoreboard queues the expected
// {pc, inst, misalign} at every PC handshake and compares on every ir handshake.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } sb_t;

    typedef struct {
        logic [31:0] pc;
        int          stall;
        bit          irr;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
    } vec_t;

    sb_t         sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // values applied at the next falling edge
    logic        d_rst = 1'b1, d_pv = 1'b0, d_flush = 1'b0, d_irr = 1'b0;
    logic        d_gnt = 1'b0, d_rvalid = 1'b0;
    logic [31:0] d_pc = 32'h0, d_rdata = 32'h0;

    bit          auto_mem   = 1'b1;
    bit          mem_pend   = 1'b0;
    logic [31:0] mem_addr_q = 32'h0;
    int          gnt_stall  = 0;
    bit          pc_hs, ir_hs;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_8000: return 32'h0050_0093;
            32'h0000_8004: return 32'h00A0_0113;
            32'h0000_8008: return 32'h0000_0513;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        sb_t e;
        @(negedge clk);
        rst          = d_rst;
        bus.pc       = d_pc;
        bus.pc_valid = d_pv;
        bus.flush    = d_flush;
        bus.ir_ready = d_irr;
        if (auto_mem) begin
            bus.imem_rvalid = mem_pend;
            bus.imem_rdata  = mem_pend ? mem_word(mem_addr_q) : 32'h0;
            mem_pend        = 1'b0;
            bus.imem_gnt    = 1'b0;
            if (bus.imem_req === 1'b1 && !d_rst) begin
                if (gnt_stall > 0) begin
                    gnt_stall--;
                end else begin
                    bus.imem_gnt = 1'b1;
                    mem_pend     = 1'b1;
                    mem_addr_q   = bus.imem_addr;
                end
            end
        end else begin
            bus.imem_gnt    = d_gnt;
            bus.imem_rvalid = d_rvalid;
            bus.imem_rdata  = d_rdata;
            mem_pend        = 1'b0;
        end
        #1;
        pc_hs = (bus.pc_valid === 1'b1) && (bus.pc_ready === 1'b1);
        ir_hs = (bus.ir_valid === 1'b1) && (bus.ir_ready === 1'b1);
        if (ir_hs) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: ir_pc=%h with no pending fetch", bus.ir_pc);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", bus.ir_pc, e.pc);
                check("sb_inst", bus.ir_inst, e.inst);
                check1("sb_mis", bus.ir_misalign, e.mis);
            end
        end
        if (d_rst || d_flush) begin
            sb_q.delete();
        end else if (pc_hs) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (bus.pc[1:0] != 2'b00)
                sb_q.push_back('{pc: bus.pc, inst: 32'h0000_0013, mis: 1'b1});
            else
`endif
                sb_q.push_back('{pc: bus.pc, inst: mem_word({bus.pc[31:2], 2'b00}), mis: 1'b0});
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        int reqs;
        gnt_stall = v.stall;
        d_irr = v.irr;
        d_pc  = v.pc;
        d_pv  = 1'b1;
        got   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (pc_hs) begin got = 1'b1; break; end
        end
        d_pv = 1'b0;
        check1("v_pc_hs", got, 1'b1);
        got  = 1'b0;
        reqs = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.imem_req === 1'b1) begin
                reqs++;
                check("v_imem_addr", bus.imem_addr, v.exp_addr);
                if (bus.imem_gnt === 1'b1) begin got = 1'b1; break; end
            end
        end
        check1("v_gnt", got, 1'b1);
        check("v_req_cycles", 32'(reqs), 32'(v.stall + 1));
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.ir_valid === 1'b1) begin got = 1'b1; break; end
        end
        check1("v_ir_valid", got, 1'b1);
        if (got) begin
            check("v_ir_pc", bus.ir_pc, v.pc);
            check("v_ir_inst", bus.ir_inst, v.exp_inst);
            check1("v_ir_mis", bus.ir_misalign, 1'b0);
        end
        if (!v.irr) begin
            d_irr = 1'b1;
            step();
        end
        d_irr = 1'b0;
    endtask

    vec_t        vecs [6];
    logic [31:0] pcs  [3];
    int          k;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_8004, 0, 1'b1, 32'h0000_8004, 32'h00A0_0113};
        vecs[1] = '{32'h0000_8010, 3, 1'b0, 32'h0000_8010, 32'hC0DE_8010};
        vecs[2] = '{32'h0000_8006, 0, 1'b0, 32'h0000_8004, 32'h00A0_0113};
        vecs[3] = '{32'hFFFF_FFFC, 1, 1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC};
        vecs[4] = '{32'h0000_0000, 2, 1'b0, 32'h0000_0000, 32'hC0DE_0000};
        vecs[5] = '{32'h0000_0003, 0, 1'b1, 32'h0000_0000, 32'hC0DE_0000};
        pcs[0] = 32'h0000_8000;
        pcs[1] = 32'h0000_8004;
        pcs[2] = 32'h0000_8008;

        // ---- reset values ----
        d_rst = 1'b1;
        step();
        step();
        check1("rst_pc_ready", bus.pc_ready, 1'b0);
        check1("rst_ir_valid", bus.ir_valid, 1'b0);
        check1("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_imem_addr", bus.imem_addr, 32'h0000_8000);
        check("rst_ir_inst", bus.ir_inst, 32'h0);
        check("rst_ir_pc", bus.ir_pc, 32'h0);
        check1("rst_ir_mis", bus.ir_misalign, 1'b0);
        d_rst = 1'b0;

        // ---- minimum latency ----
        d_pc = 32'h0000_8000;
        d_pv = 1'b1;
        step();
        check1("lat_pc_ready", bus.pc_ready, 1'b1);
        d_pv = 1'b0;
        step();
        check1("lat_imem_req", bus.imem_req, 1'b1);
        check("lat_imem_addr", bus.imem_addr, 32'h0000_8000);
        step();
        check1("lat_ir_valid_early", bus.ir_valid, 1'b0);
        step();
        check1("lat_ir_valid", bus.ir_valid, 1'b1);
        check("lat_ir_pc", bus.ir_pc, 32'h0000_8000);
        check("lat_ir_inst", bus.ir_inst, 32'h0050_0093);
        d_irr = 1'b1;
        step();
        d_irr = 1'b0;
        step();

        // ---- backpressure: FIFO fills at two, third PC waits for a pop ----
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            d_pv = 1'b1;
            d_pc = pcs[k];
            step();
            if (pc_hs) k++;
        end
        check("bp_accepted", 32'(k), 32'd2);
        check1("bp_pc_ready_full", bus.pc_ready, 1'b0);
        check("bp_head_pc", bus.ir_pc, 32'h0000_8000);
        d_irr = 1'b1;
        d_pc  = pcs[2];
        step();
        check1("bp_pop", ir_hs, 1'b1);
        check1("bp_hs_on_pop", pc_hs, 1'b1);
        d_pv = 1'b0;
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) step();
        check("bp_drained", 32'(sb_q.size()), 32'd0);
        d_irr = 1'b0;

        // ---- table-driven single fetches ----
        for (int i = 0; i < 6; i++) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (vecs[i].pc[1:0] != 2'b00) continue;
`endif
            run_vec(vecs[i]);
        end

        // ---- flush in WAIT_DATA, late response dropped ----
        auto_mem = 1'b0;
        d_pc = 32'h0000_8000;
        d_pv = 1'b1;
        step();
        d_pv  = 1'b0;
        d_gnt = 1'b1;
        step();
        check1("fw_imem_req", bus.imem_req, 1'b1);
        d_gnt   = 1'b0;
        d_flush = 1'b1;
        step();
        d_flush = 1'b0;
        step();
        check1("fw_drain_pc_ready", bus.pc_ready, 1'b0);
        d_rvalid = 1'b1;
        d_rdata  = 32'hDEAD_BEEF;
        step();
        d_rvalid = 1'b0;
        step();
        check1("fw_ir_valid", bus.ir_valid, 1'b0);
        check1("fw_pc_ready", bus.pc_ready, 1'b1);
        step();
        check1("fw_ir_valid_late", bus.ir_valid, 1'b0);
        auto_mem = 1'b1;
        run_vec('{32'h0000_9000, 0, 1'b1, 32'h0000_9000, 32'hC0DE_9000});

        // ---- flush and response in the same cycle ----
        auto_mem = 1'b0;
        d_pc = 32'h0000_8004;
        d_pv = 1'b1;
        step();
        d_pv  = 1'b0;
        d_gnt = 1'b1;
        step();
        d_gnt    = 1'b0;
        d_flush  = 1'b1;
        d_rvalid = 1'b1;
        d_rdata  = 32'h1234_5678;
        step();
        d_flush  = 1'b0;
        d_rvalid = 1'b0;
        step();
        check1("fr_ir_valid", bus.ir_valid, 1'b0);
        check1("fr_pc_ready", bus.pc_ready, 1'b1);

        // ---- flush in REQ withdraws an ungranted request ----
        d_pc = 32'h0000_8008;
        d_pv = 1'b1;
        step();
        d_pv = 1'b0;
        step();
        check1("fq_imem_req", bus.imem_req, 1'b1);
        d_flush = 1'b1;
        step();
        d_flush = 1'b0;
        step();
        check1("fq_imem_req_drop", bus.imem_req, 1'b0);
        check1("fq_pc_ready", bus.pc_ready, 1'b1);

        // ---- flush with full FIFO and a pop in the same cycle ----
        auto_mem = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            d_pv = 1'b1;
            d_pc = pcs[k];
            step();
            if (pc_hs) k++;
        end
        d_pv = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check1("ff_full", bus.pc_ready, 1'b0);
        d_flush = 1'b1;
        d_irr   = 1'b1;
        step();
        d_flush = 1'b0;
        d_irr   = 1'b0;
        step();
        check1("ff_ir_valid", bus.ir_valid, 1'b0);
        check1("ff_pc_ready", bus.pc_ready, 1'b1);

        // ---- reset mid-fetch, stale response ignored ----
        auto_mem = 1'b0;
        d_pc = 32'h0000_9000;
        d_pv = 1'b1;
        step();
        d_pv  = 1'b0;
        d_gnt = 1'b1;
        step();
        d_gnt = 1'b0;
        d_rst = 1'b1;
        step();
        d_rst    = 1'b0;
        d_rvalid = 1'b1;
        d_rdata  = 32'hBAD0_BAD0;
        step();
        d_rvalid = 1'b0;
        step();
        check1("rm_ir_valid", bus.ir_valid, 1'b0);
        check1("rm_imem_req", bus.imem_req, 1'b0);
        check("rm_imem_addr", bus.imem_addr, 32'h0000_8000);
        check1("rm_pc_ready", bus.pc_ready, 1'b1);
        auto_mem = 1'b1;

`ifdef FETCH_MISALIGN_CHK_EN
        // ---- misaligned PC produces a marker without a memory request ----
        d_pc = 32'h0000_8002;
        d_pv = 1'b1;
        step();
        check1("ma_pc_hs", pc_hs, 1'b1);
        d_pv = 1'b0;
        step();
        check1("ma_imem_req", bus.imem_req, 1'b0);
        check1("ma_ir_valid", bus.ir_valid, 1'b1);
        check1("ma_ir_mis", bus.ir_misalign, 1'b1);
        check("ma_ir_inst", bus.ir_inst, 32'h0000_0013);
        check("ma_ir_pc", bus.ir_pc, 32'h0000_8002);
        d_irr = 1'b1;
        step();
        d_irr = 1'b0;
        step();
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
